// File: rtl/serial_arith_pkg.sv
// Shared FSM encoding and operation-mode constants for the serial adder.
package serial_arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, a, b, cin,
    input  s, cout, ovf, busy, done
  );

  modport slave (
    input  start, mode, a, b, cin,
    output s, cout, ovf, busy, done
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, results committed atomically.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH:0]   sum_ext_c;
  logic [WIDTH-1:0] sum_next_c;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // A request is taken whenever no operation is in flight.
  assign accept_c   = bus.start && (state != ST_RUN);
  assign last_c     = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign sum_ext_c  = {fa_s, sum_sr};
  assign sum_next_c = sum_ext_c[WIDTH:1];

  full_adder_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: RUN for WIDTH cycles, FIN for one, chaining on a new request.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept_c) next_state = ST_RUN;
      ST_RUN:  if (last_c)   next_state = ST_FIN;
      ST_FIN:  next_state = accept_c ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Operand capture, per-bit shifting and atomic result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b ^ {WIDTH{bus.mode}};
        carry  <= (bus.mode == MODE_SUB) ? 1'b1 : bus.cin;
        sum_sr <= '0;
        cnt    <= '0;
      end else if (state == ST_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_next_c;
        carry  <= fa_co;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last_c) begin
        s_q    <= sum_next_c;
        cout_q <= fa_co;
        ovf_q  <= carry ^ fa_co;
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (next_state == ST_RUN);
      done_q <= (next_state == ST_FIN);
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request; sampled on rising CLK, accepted only when BUSY=0.
REQ-005 MODE  input  1  0 = add, 1 = subtract (A-B); sampled with START.
REQ-006 A  input  WIDTH  operand A; sampled with START.
REQ-007 B  input  WIDTH  operand B; sampled with START.
REQ-008 CIN  input  1  carry-in for add; ignored in subtract; sampled with START.
REQ-009 S  output  WIDTH  registered result.
REQ-010 COUT  output  1  carry-out (add) / no-borrow flag (subtract).
REQ-011 OVF  output  1  two's-complement overflow of the last result.
REQ-012 BUSY  output  1  high while an operation is in progress (RUN state).
REQ-013 DONE  output  1  one-cycle pulse; S/COUT/OVF are valid from this cycle.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIN; encoding is free.
REQ-015 An accepted START in IDLE or FIN SHALL capture A, B^{WIDTH{MODE}}, initial carry (MODE ? 1 : CIN), clear the bit counter and enter RUN.
REQ-016 RUN SHALL process one bit per cycle, LSB first, through one full-adder cell: sum bit into a shift register, carry into the carry flop.
REQ-017 After exactly WIDTH RUN cycles the FSM SHALL enter FIN; FIN lasts one cycle, then IDLE unless START is accepted in FIN.
REQ-018 Latency: START sampled at edge n -> DONE high in the cycle after edge n+WIDTH, for exactly one cycle.
REQ-019 S, COUT, OVF SHALL update atomically on the edge entering FIN and hold until the next completion; partial sums never appear on S.
REQ-020 OVF SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-021 START while BUSY=1 SHALL be ignored; operands and state unaffected.
REQ-022 START accepted in FIN (back-to-back) SHALL begin the new operation with no idle cycle; DONE still pulses for the completing operation.
REQ-023 BUSY SHALL be 1 exactly in RUN; DONE SHALL be 1 exactly in FIN.
REQ-024 Arithmetic is modulo 2^WIDTH; WIDTH=1 SHALL work (one RUN cycle).

Reset
REQ-025 RST_N low SHALL asynchronously force IDLE, S=0, COUT=0, OVF=0, BUSY=0, DONE=0, counter and shift registers 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no DONE pulse is produced for it.
REQ-027 Deassertion SHALL be synchronous to CLK; START is honoured from the first edge after deassertion.

Structure
REQ-028 FSM state typedef and the MODE_ADD/MODE_SUB constants SHALL live in a shared package serial_arith_pkg.
REQ-029 The one-bit full adder SHALL be a separate sub-module full_adder_cell (A, B, CI -> S, CO), instantiated once.
REQ-030 Bit counter width SHALL be $clog2(WIDTH+1); no other derived constants hard-coded.

Verification (WIDTH=8 unless stated)
REQ-031 A=0xFF, B=0x01, CIN=0, MODE=0, START at edge 0 -> DONE at cycle 9, S=0x00, COUT=1, OVF=0.
REQ-032 A=0x7F, B=0x01, MODE=0 -> S=0x80, COUT=0, OVF=1; A=0x05, B=0x07, MODE=1 -> S=0xFE, COUT=0, OVF=0.
REQ-033 START with A=0x11 pulsed at cycle 3 of a running op -> ignored; first op's result and DONE timing unchanged.
REQ-034 RST_N low at cycle 4 of RUN -> all outputs 0 immediately, no DONE; new START after release completes correctly.
REQ-035 START held high continuously with changing operands -> results every WIDTH+1 cycles, DONE pulses back-to-back, each result correct.
REQ-036 WIDTH=1: A=1, B=1, CIN=1 -> DONE at cycle 2, S=1, COUT=1, OVF=0.
